dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 32 +++
 rtl/dmem_arbiter.sv | 106 ++++++++++
 tb/tb_dmem_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the data-memory port of dmem_arbiter.
// slave  : the arbiter's view (requests in, grants/responses/memory bus out)
// master : the environment's view (requesters plus the data memory)
interface dmem_arbiter_if;
  logic        req0, req1;
  logic        we0, we1;
  logic        lock0, lock1;
  logic [31:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1;
  logic        rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic        err0, err1;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic [31:0] mem_read_data;

  modport slave (
    input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1,
    input  mem_read_data,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
    output mem_addr, mem_write_data, mem_write
  );

  modport master (
    output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1,
    output mem_read_data,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
    input  mem_addr, mem_write_data, mem_write
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a single-port data memory.
// Round-robin on contention, optional lock for atomic read-modify-write,
// range/alignment checking, and a one-cycle registered response per requester.
module dmem_arbiter #(
  parameter int DATA_MEM_SIZE = 64
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  logic [1:0]  w_req, w_we, w_lock, w_legal, w_gnt;
  logic [31:0] w_addr  [2];
  logic [31:0] w_wdata [2];
  logic        w_any, w_sel;

  logic        r_last;
  logic        r_owner_valid;
  logic        r_owner;

  assign w_req     = {bus.req1, bus.req0};
  assign w_we      = {bus.we1, bus.we0};
  assign w_lock    = {bus.lock1, bus.lock0};
  assign w_addr[0] = bus.addr0;
  assign w_addr[1] = bus.addr1;
  assign w_wdata[0] = bus.wdata0;
  assign w_wdata[1] = bus.wdata1;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_legal
      // word-aligned and inside the memory
      assign w_legal[gi] = (w_addr[gi][1:0] == 2'b00) &&
                           ({2'b00, w_addr[gi][31:2]} < 32'(DATA_MEM_SIZE));
    end
  endgenerate

  // grant decision: locked owner first, else single requester, else the one not served last
  always_comb begin
    w_gnt = 2'b00;
    if (!rst) begin
      if (r_owner_valid)
        w_gnt[r_owner] = w_req[r_owner];
      else if (&w_req)
        w_gnt[~r_last] = 1'b1;
      else
        w_gnt = w_req;
    end
  end

  assign w_any = |w_gnt;
  assign w_sel = w_gnt[1];

  assign bus.gnt0           = w_gnt[0];
  assign bus.gnt1           = w_gnt[1];
  assign bus.mem_addr       = w_any ? w_addr[w_sel]  : 32'h0;
  assign bus.mem_write_data = w_any ? w_wdata[w_sel] : 32'h0;
  // out-of-range or misaligned writes never reach memory
  assign bus.mem_write      = w_any && w_we[w_sel] && w_legal[w_sel];

  // round-robin pointer and lock ownership tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last        <= 1'b1;
      r_owner_valid <= 1'b0;
      r_owner       <= 1'b0;
    end else if (w_any) begin
      r_last        <= w_sel;
      r_owner_valid <= w_lock[w_sel];
      r_owner       <= w_sel;
    end else if (r_owner_valid && !w_lock[r_owner]) begin
      r_owner_valid <= 1'b0;
    end
  end

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rsp
      logic        r_rvalid;
      logic [31:0] r_rdata;
      logic        r_err;

      // one-cycle response; data and error hold until the next response
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_rvalid <= 1'b0;
          r_rdata  <= 32'h0;
          r_err    <= 1'b0;
        end else begin
          r_rvalid <= w_gnt[gi];
          if (w_gnt[gi]) begin
            r_rdata <= (w_legal[gi] && !w_we[gi]) ? bus.mem_read_data : 32'h0;
            r_err   <= ~w_legal[gi];
          end
        end
      end
    end
  endgenerate

  assign bus.rvalid0 = g_rsp[0].r_rvalid;
  assign bus.rvalid1 = g_rsp[1].r_rvalid;
  assign bus.rdata0  = g_rsp[0].r_rdata;
  assign bus.rdata1  = g_rsp[1].r_rdata;
  assign bus.err0    = g_rsp[0].r_err;
  assign bus.err1    = g_rsp[1].r_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_dmem_arbiter;
  localparam int DMS = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.DATA_MEM_SIZE(DMS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // data memory attached to the arbiter
  logic [31:0] tb_mem [DMS];
  assign bus.mem_read_data = (bus.mem_addr[31:2] < DMS) ? tb_mem[bus.mem_addr[7:2]] : 32'hBAD0BAD0;
  always @(posedge clk)
    if (bus.mem_write && bus.mem_addr[31:2] < DMS)
      tb_mem[bus.mem_addr[7:2]] <= bus.mem_write_data;

  // requester stimulus
  bit          s_req [2];
  bit          s_we  [2];
  bit          s_lock[2];
  logic [31:0] s_addr [2];
  logic [31:0] s_wdata[2];

  // reference model
  logic [31:0] model_mem [DMS];
  int          m_last, m_owner;
  bit          m_locked;
  bit          m_rvalid[2];
  logic [31:0] m_rdata [2];
  bit          m_err   [2];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit is_legal(input logic [31:0] a);
    return (a % 4 == 0) && (a / 4 < DMS);
  endfunction

  task automatic model_reset();
    m_last   = 1;
    m_owner  = 0;
    m_locked = 0;
    for (int n = 0; n < 2; n++) begin
      m_rvalid[n] = 0;
      m_rdata[n]  = 32'h0;
      m_err[n]    = 0;
    end
  endtask

  task automatic drive();
    bus.req0 = s_req[0];   bus.req1 = s_req[1];
    bus.we0  = s_we[0];    bus.we1  = s_we[1];
    bus.lock0 = s_lock[0]; bus.lock1 = s_lock[1];
    bus.addr0 = s_addr[0]; bus.addr1 = s_addr[1];
    bus.wdata0 = s_wdata[0]; bus.wdata1 = s_wdata[1];
  endtask

  task automatic set_req(input int n, input bit r, input bit w, input bit l,
                         input logic [31:0] a, input logic [31:0] d);
    s_req[n] = r; s_we[n] = w; s_lock[n] = l; s_addr[n] = a; s_wdata[n] = d;
  endtask

  // one clock cycle: starts and ends at a falling edge
  task automatic cycle(output int g);
    bit lg;
    drive();
    #1;
    // who should win this cycle
    g = -1;
    if (m_locked) begin
      if (s_req[m_owner]) g = m_owner;
    end else if (s_req[0] && s_req[1]) begin
      g = 1 - m_last;
    end else if (s_req[0]) begin
      g = 0;
    end else if (s_req[1]) begin
      g = 1;
    end
    lg = (g >= 0) ? is_legal(s_addr[g]) : 1'b0;

    check_eq("gnt0", 32'(bus.gnt0), 32'(g == 0));
    check_eq("gnt1", 32'(bus.gnt1), 32'(g == 1));
    check_eq("mem_addr", bus.mem_addr, (g >= 0) ? s_addr[g] : 32'h0);
    check_eq("mem_write_data", bus.mem_write_data, (g >= 0) ? s_wdata[g] : 32'h0);
    check_eq("mem_write", 32'(bus.mem_write), 32'((g >= 0) && s_we[g] && lg));
    check_eq("rvalid0", 32'(bus.rvalid0), 32'(m_rvalid[0]));
    check_eq("rvalid1", 32'(bus.rvalid1), 32'(m_rvalid[1]));
    check_eq("rdata0", bus.rdata0, m_rdata[0]);
    check_eq("rdata1", bus.rdata1, m_rdata[1]);
    check_eq("err0", 32'(bus.err0), 32'(m_err[0]));
    check_eq("err1", 32'(bus.err1), 32'(m_err[1]));

    // advance the model
    for (int n = 0; n < 2; n++) m_rvalid[n] = (g == n);
    if (g >= 0) begin
      m_rdata[g] = (lg && !s_we[g]) ? model_mem[s_addr[g] / 4] : 32'h0;
      m_err[g]   = !lg;
      if (lg && s_we[g]) model_mem[s_addr[g] / 4] = s_wdata[g];
      m_last   = g;
      m_owner  = g;
      m_locked = s_lock[g];
      $display("txn cyc=%0d req%0d %s addr=%h wdata=%h lock=%0d legal=%0d",
               cyc, g, s_we[g] ? "WR" : "RD", s_addr[g], s_wdata[g], s_lock[g], lg);
    end else if (m_locked && !s_lock[m_owner]) begin
      m_locked = 0;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic rand_req(input int n);
    int k;
    s_req[n]   = ($urandom_range(0, 3) != 0);
    s_we[n]    = $urandom_range(0, 1);
    s_wdata[n] = $urandom;
    k = $urandom_range(0, 9);
    if (k == 0)      s_addr[n] = $urandom;
    else if (k == 1) s_addr[n] = {24'h0, 6'($urandom), 2'($urandom_range(1, 3))};
    else             s_addr[n] = {24'h0, 6'($urandom), 2'b00};
  endtask

  initial begin
    int g;
    for (int i = 0; i < DMS; i++) begin
      tb_mem[i]    = $urandom;
      model_mem[i] = tb_mem[i];
    end
    model_reset();
    // a request present during reset must not be granted
    set_req(0, 1, 0, 0, 32'h0, 32'h0);
    set_req(1, 1, 1, 0, 32'h4, 32'h1234);
    drive();
    repeat (2) @(negedge clk);
    check_eq("rst_gnt0", 32'(bus.gnt0), 32'h0);
    check_eq("rst_gnt1", 32'(bus.gnt1), 32'h0);
    check_eq("rst_mem_write", 32'(bus.mem_write), 32'h0);
    check_eq("rst_mem_addr", bus.mem_addr, 32'h0);
    check_eq("rst_mem_wdata", bus.mem_write_data, 32'h0);
    check_eq("rst_rvalid", {30'h0, bus.rvalid1, bus.rvalid0}, 32'h0);
    check_eq("rst_rdata0", bus.rdata0, 32'h0);
    check_eq("rst_err", {30'h0, bus.err1, bus.err0}, 32'h0);
    rst = 1'b0;

    // contention: grants alternate 0,1,0,1
    set_req(0, 1, 0, 0, 32'h8, 32'h0);
    set_req(1, 1, 0, 0, 32'hC, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cycle(g);
      check_eq("rr_grant", 32'(g), 32'(i % 2));
      if (i > 0) begin
        check_eq("rr_rdata", (i % 2 == 1) ? bus.rdata0 : bus.rdata1,
                 (i % 2 == 1) ? model_mem[2] : model_mem[3]);
      end
    end
    set_req(0, 0, 0, 0, 32'h0, 32'h0);
    set_req(1, 0, 0, 0, 32'h0, 32'h0);
    cycle(g);

    // write then read through requester 1
    set_req(1, 1, 1, 0, 32'h10, 32'hDEADBEEF);
    cycle(g);
    set_req(1, 1, 0, 0, 32'h10, 32'h0);
    cycle(g);
    set_req(1, 0, 0, 0, 32'h0, 32'h0);
    cycle(g);
    check_eq("wr_rd_rdata1", bus.rdata1, 32'hDEADBEEF);
    check_eq("wr_rd_err1", 32'(bus.err1), 32'h0);

    // lock: requester 0 keeps the memory while lock0 is high
    set_req(0, 1, 0, 1, 32'h20, 32'h0);
    set_req(1, 1, 0, 0, 32'h24, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cycle(g);
      check_eq("lock_grant", 32'(g), 32'h0);
    end
    set_req(0, 0, 0, 0, 32'h20, 32'h0);
    cycle(g);
    check_eq("lock_wait", 32'(g), 32'hFFFFFFFF);
    set_req(0, 1, 0, 0, 32'h20, 32'h0);
    cycle(g);
    check_eq("unlock_grant", 32'(g), 32'h1);
    set_req(0, 0, 0, 0, 32'h0, 32'h0);
    set_req(1, 0, 0, 0, 32'h0, 32'h0);
    cycle(g);

    // illegal accesses
    set_req(0, 1, 1, 0, 32'h100, 32'hCAFEF00D);
    cycle(g);
    check_eq("oor_rvalid0", 32'(bus.rvalid0), 32'h1);
    check_eq("oor_err0", 32'(bus.err0), 32'h1);
    check_eq("oor_rdata0", bus.rdata0, 32'h0);
    set_req(0, 1, 0, 0, 32'h6, 32'h0);
    cycle(g);
    check_eq("mis_err0", 32'(bus.err0), 32'h1);
    set_req(0, 0, 0, 0, 32'h0, 32'h0);
    cycle(g);

    // reset between a grant and its response
    set_req(0, 1, 0, 0, 32'h4, 32'h0);
    set_req(1, 0, 0, 0, 32'h0, 32'h0);
    drive();
    #1;
    check_eq("pre_rst_gnt0", 32'(bus.gnt0), 32'h1);
    #1 rst = 1'b1;
    #1;
    check_eq("mid_rst_gnt0", 32'(bus.gnt0), 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_eq("mid_rst_rvalid0", 32'(bus.rvalid0), 32'h0);
    set_req(0, 0, 0, 0, 32'h0, 32'h0);
    drive();
    rst = 1'b0;
    cycle(g);
    set_req(0, 1, 0, 0, 32'h8, 32'h0);
    set_req(1, 1, 0, 0, 32'hC, 32'h0);
    cycle(g);
    check_eq("post_rst_grant", 32'(g), 32'h0);

    // randomized traffic; requests stay up until granted
    rand_req(0);
    rand_req(1);
    for (int i = 0; i < 400; i++) begin
      for (int n = 0; n < 2; n++) s_lock[n] = ($urandom_range(0, 3) == 0);
      cycle(g);
      for (int n = 0; n < 2; n++)
        if (g == n || !s_req[n]) rand_req(n);
    end
    set_req(0, 0, 0, 0, 32'h0, 32'h0);
    set_req(1, 0, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) cycle(g);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
